// File: rtl/stone_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : stone_renderer
//  Description : Sweeps the rope/stone controller's item RAM once per frame
//                and emits a clipped SIZE x SIZE square of pixel writes for
//                every visible item, coloured by item type. Owns the RAM read
//                address (draw_stone_flag) for the whole sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module stone_renderer #(
    parameter int         RAM_LATENCY = 2,   // expected >= 2
    parameter int         SIZE        = 16,  // power of two
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter logic [8:0] COL_STONE   = 9'b100100100,
    parameter logic [8:0] COL_GOLD    = 9'b111110000,
    parameter logic [8:0] COL_DIAMOND = 9'b000111111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] item_data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [8:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int            c_PW  = $clog2(SIZE);
    localparam logic [c_PW-1:0] c_MAX = c_PW'(SIZE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]      r_state;
    logic [7:0]      r_wait;
    logic [8:0]      r_rx;
    logic [7:0]      r_ry;
    logic [1:0]      r_type;
    logic [c_PW-1:0] r_dx;
    logic [c_PW-1:0] r_dy;

    logic [c_PW-1:0] w_ndx;
    logic [c_PW-1:0] w_ndy;
    logic            w_last;
    logic [8:0]      w_bx;
    logic [7:0]      w_by;
    logic [c_PW-1:0] w_ox;
    logic [c_PW-1:0] w_oy;
    logic [1:0]      w_typ;
    logic [9:0]      w_sx;
    logic [9:0]      w_sy;
    logic            w_onscreen;
    logic [8:0]      w_col;
    logic            w_unused_bits;

    // Fields of the record the renderer does not consume.
    assign w_unused_bits = ^{item_data[31:28], item_data[18:15], item_data[6:4], item_data[0]};

    // Row-major successor of the pixel currently on the outputs.
    assign w_last = (r_dx == c_MAX) && (r_dy == c_MAX);
    assign w_ndx  = r_dx + 1'b1;
    assign w_ndy  = (r_dx == c_MAX) ? r_dy + 1'b1 : r_dy;

    // Pixel being registered next: the square origin when latching, otherwise
    // the successor pixel, so the outputs are aligned with the DRAW cycles.
    always_comb begin
        w_bx  = r_rx;
        w_by  = r_ry;
        w_ox  = w_ndx;
        w_oy  = w_ndy;
        w_typ = r_type;
        if (r_state == S_LATCH) begin
            w_bx  = item_data[27:19];
            w_by  = item_data[14:7];
            w_ox  = '0;
            w_oy  = '0;
            w_typ = item_data[3:2];
        end
    end

    // Clip on the unwrapped 10-bit sums so the square may hang off the edge.
    assign w_sx       = {1'b0, w_bx} + 10'(w_ox);
    assign w_sy       = {2'b00, w_by} + 10'(w_oy);
    assign w_onscreen = (w_sx < 10'(SCREEN_W)) && (w_sy < 10'(SCREEN_H));

    // Colour lookup by item type; both diamond encodings share one colour.
    always_comb begin
        w_col = COL_DIAMOND;
        case (w_typ)
            2'b00:   w_col = COL_STONE;
            2'b01:   w_col = COL_GOLD;
            default: w_col = COL_DIAMOND;
        endcase
    end

    // Sweep controller with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait          <= '0;
            r_rx            <= '0;
            r_ry            <= '0;
            r_type          <= '0;
            r_dx            <= '0;
            r_dy            <= '0;
            draw_stone_flag <= 1'b0;
            draw_index      <= '0;
            x               <= '0;
            y               <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (quantity == 4'd0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            draw_index      <= '0;
                            draw_stone_flag <= 1'b1;
                            busy            <= 1'b1;
                            r_state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_wait  <= 8'(RAM_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                // REQ plus RAM_LATENCY-1 wait cycles puts LATCH exactly
                // RAM_LATENCY cycles after the address change.
                S_WAIT: begin
                    if (r_wait <= 8'd1) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                S_LATCH: begin
                    r_rx   <= item_data[27:19];
                    r_ry   <= item_data[14:7];
                    r_type <= item_data[3:2];
                    r_dx   <= '0;
                    r_dy   <= '0;
                    if (item_data[1]) begin
                        x       <= w_sx[8:0];
                        y       <= w_sy[7:0];
                        colour  <= w_col;
                        plot    <= w_onscreen;
                        r_state <= S_DRAW;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (w_last) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_dx   <= w_ndx;
                        r_dy   <= w_ndy;
                        x      <= w_sx[8:0];
                        y      <= w_sy[7:0];
                        colour <= w_col;
                        plot   <= w_onscreen;
                    end
                end
                S_NEXT: begin
                    if (draw_index == quantity - 4'd1) begin
                        draw_stone_flag <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        draw_index <= draw_index + 4'd1;
                        r_state    <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stone_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stone_renderer
//  Description : Directed self-checking bench for stone_renderer with a
//                RAM model that only presents the addressed record in the
//                cycle RAM_LATENCY after each address change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stone_renderer;

    localparam int c_LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] item_data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [8:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    stone_renderer u_dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .quantity       (quantity),
        .item_data      (item_data),
        .draw_stone_flag(draw_stone_flag),
        .draw_index     (draw_index),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // RAM model: correct record only in the cycle that starts RAM_LATENCY
    // edges after draw_index changed (or the flag rose); garbage otherwise.
    logic [31:0] mem [16];
    int          r_k       = 100;
    logic [3:0]  r_prev_i  = '0;
    logic        r_prev_f  = 1'b0;
    logic [31:0] r_garbage;

    always @(posedge clock) begin
        #1;
        if ((draw_index != r_prev_i) || (draw_stone_flag && !r_prev_f))
            r_k = 0;
        else if (r_k < 100)
            r_k = r_k + 1;
        r_prev_i = draw_index;
        r_prev_f = draw_stone_flag;
        if (r_k == c_LAT) begin
            item_data = mem[draw_index];
        end else begin
            r_garbage       = $urandom;
            r_garbage[3:1]  = 3'b001;   // visible stone at random coordinates
            item_data       = r_garbage;
        end
    end

    // Pixel monitor against the expected pixel stream.
    typedef struct packed {
        logic [8:0] px;
        logic [7:0] py;
        logic [8:0] pc;
    } pix_t;

    pix_t       exp_q[$];
    logic [3:0] idx_seq[$];
    pix_t       mon_p;
    int         plot_cnt    = 0;
    int         pix_err     = 0;
    int         done_cnt    = 0;
    int         flag_hi_cnt = 0;
    logic [16:0] first_xy;
    logic [16:0] last_xy;
    logic       mon_pf      = 1'b0;
    logic [3:0] mon_pi      = '0;

    always @(negedge clock) begin
        if (plot === 1'b1) begin
            if (plot_cnt == 0) first_xy = {x, y};
            last_xy = {x, y};
            plot_cnt++;
            if (exp_q.size() == 0) begin
                pix_err++;
            end else begin
                mon_p = exp_q.pop_front();
                if (mon_p != {x, y, colour}) pix_err++;
            end
            if (draw_stone_flag !== 1'b1) pix_err++;
        end
        if (done === 1'b1) done_cnt++;
        if (draw_stone_flag === 1'b1) begin
            flag_hi_cnt++;
            if (!mon_pf || draw_index != mon_pi) idx_seq.push_back(draw_index);
        end
        mon_pf = (draw_stone_flag === 1'b1);
        mon_pi = draw_index;
    end

    function automatic logic [8:0] col_of(input logic [1:0] t);
        case (t)
            2'b00:   return 9'b100100100;
            2'b01:   return 9'b111110000;
            default: return 9'b000111111;
        endcase
    endfunction

    // Store a record and queue the pixels it must produce.
    task automatic add_item(input int idx, input int xx, input int yy,
                            input logic [1:0] t, input bit vis, input bit mov);
        int sx;
        int sy;
        mem[idx] = {13'(xx), 12'(yy), 3'b000, t, vis, mov};
        if (vis) begin
            for (int dy = 0; dy < 16; dy++) begin
                for (int dx = 0; dx < 16; dx++) begin
                    sx = (xx % 512) + dx;
                    sy = (yy % 256) + dy;
                    if (sx < 320 && sy < 240)
                        exp_q.push_back({9'(sx), 8'(sy), col_of(t)});
                end
            end
        end
    endtask

    // One sweep: start, wait for done, then check length, counts and stream.
    task automatic run_sweep(input string tag, input int q, input int nvis,
                             input int exp_plots, input int mid_start_at);
        int cyc;
        int len;
        bit seen;
        cyc  = 0;
        seen = 0;
        len  = 2 + q * (2 + c_LAT) + nvis * 256;
        plot_cnt    = 0;
        pix_err     = 0;
        done_cnt    = 0;
        flag_hi_cnt = 0;
        idx_seq.delete();
        @(negedge clock);
        quantity = 4'(q);
        start    = 1'b1;
        while (!seen && cyc < 4000) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (cyc == mid_start_at) start = 1'b1;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        check({tag, "_done_seen"}, 64'(seen), 1);
        check({tag, "_len_in_window"}, 64'(cyc >= len - 1 && cyc <= len + 1), 1);
        check({tag, "_done_once"}, 64'(done_cnt), 1);
        check({tag, "_plots"}, 64'(plot_cnt), 64'(exp_plots));
        check({tag, "_pix_err"}, 64'(pix_err), 0);
        check({tag, "_pix_left"}, 64'(exp_q.size()), 0);
        check({tag, "_flag_cycles"}, 64'(flag_hi_cnt), (q == 0) ? 0 : 64'(cyc - 1));
        check({tag, "_idle_busy"}, {63'd0, busy}, 0);
        check({tag, "_idle_flag"}, {63'd0, draw_stone_flag}, 0);
        check({tag, "_idx_count"}, 64'(idx_seq.size()), 64'(q));
        for (int i = 0; i < idx_seq.size(); i++)
            check({tag, "_idx_seq"}, 64'(idx_seq[i]), 64'(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        quantity = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clock);
        check("rst_flag",   {63'd0, draw_stone_flag}, 0);
        check("rst_index",  64'(draw_index), 0);
        check("rst_pixel",  {38'd0, x, y, colour}, 0);
        check("rst_plot",   {63'd0, plot}, 0);
        check("rst_busy",   {63'd0, busy}, 0);
        check("rst_done",   {63'd0, done}, 0);
        reset = 1'b0;

        // Empty list: immediate done, no plots, RAM never claimed.
        run_sweep("q0", 0, 0, 0, 0);

        // Single gold square fully on screen.
        exp_q.delete();
        add_item(0, 100, 50, 2'b01, 1'b1, 1'b0);
        run_sweep("q1", 1, 1, 256, 0);
        check("q1_first_xy", 64'(first_xy), {47'd0, 9'd100, 8'd50});
        check("q1_last_xy",  64'(last_xy),  {47'd0, 9'd115, 8'd65});

        // Three items, middle invisible, X carries ignored upper bits,
        // last item moving.
        exp_q.delete();
        add_item(0, 4096 + 40, 10, 2'b01, 1'b1, 1'b0);
        add_item(1, 200, 100, 2'b10, 1'b0, 1'b0);
        add_item(2, 150, 120, 2'b11, 1'b1, 1'b1);
        run_sweep("q3", 3, 2, 512, 0);

        // Square clipped at the bottom-right corner.
        exp_q.delete();
        add_item(0, 310, 230, 2'b10, 1'b1, 1'b0);
        run_sweep("clip", 1, 1, 100, 0);

        // Second start mid-sweep must be ignored.
        exp_q.delete();
        add_item(0, 60, 70, 2'b00, 1'b1, 1'b0);
        run_sweep("midstart", 1, 1, 256, 100);

        // Reset during pixel index 37 of a sweep.
        exp_q.delete();
        add_item(0, 20, 20, 2'b01, 1'b1, 1'b0);
        n = 0;
        @(negedge clock);
        quantity = 4'd1;
        start    = 1'b1;
        for (int c = 0; c < 400 && n < 38; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (plot === 1'b1) n++;
        end
        check("rst_mid_reached", 64'(n), 38);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_plot", {63'd0, plot}, 0);
        check("rst_mid_busy", {63'd0, busy}, 0);
        check("rst_mid_flag", {63'd0, draw_stone_flag}, 0);
        check("rst_mid_done", {63'd0, done}, 0);
        check("rst_mid_index", 64'(draw_index), 0);
        reset = 1'b0;

        // Fresh sweep after the reset.
        exp_q.delete();
        add_item(0, 200, 180, 2'b11, 1'b1, 1'b0);
        run_sweep("post_rst", 1, 1, 256, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stone_renderer.md
Name: stone_renderer

Overview:
- Downstream consumer of the rope/stone controller's item RAM.
- On each frame-start pulse, sweeps item indices 0..quantity-1 and reads each 32-bit item record through the controller's draw port (draw_stone_flag / draw_index / data).
- Emits one VGA-adapter pixel write per pixel of a 16x16 square for every visible item, coloured by item type.
- Holds draw_stone_flag for the whole sweep, so the controller's frame-step states stall while RAM is owned by the renderer.

Parameters:
- RAM_LATENCY, 2, cycles from draw_index change to valid item_data.
- SIZE, 16, square edge in pixels (power of two).
- SCREEN_W, 320, horizontal clip limit.
- SCREEN_H, 240, vertical clip limit.
- COL_STONE, 9'b100100100, colour for type 2'b00.
- COL_GOLD, 9'b111110000, colour for type 2'b01.
- COL_DIAMOND, 9'b000111111, colour for types 2'b10 and 2'b11.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame-start pulse; begins a sweep when idle.
- quantity  in  4  number of item records to sweep.
- item_data  in  32  record from item RAM. Fields: [31:19] X, [18:7] Y, [3:2] type, [1] visible, [0] moving.
- draw_stone_flag  out  1  high while the renderer owns the RAM read address.
- draw_index  out  4  RAM address being read.
- x  out  9  pixel x.
- y  out  8  pixel y.
- colour  out  9  pixel colour.
- plot  out  1  pixel write strobe, valid with x/y/colour.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.

Behaviour:
- Reset (synchronous, active-high): every output is 0 on the following edge, state returns to S_IDLE, and the index counter clears. This applies mid-sweep as well; no further plot pulses occur after the reset edge.
- S_IDLE: busy=0, draw_stone_flag=0.
  - If start=1 and quantity==0: go to S_DONE.
  - If start=1 and quantity!=0: draw_index<=0, go to S_REQ.
  - start while busy is ignored, with no queuing.
- S_REQ: draw_stone_flag=1, busy=1. Load the wait counter with RAM_LATENCY-1, then go to S_WAIT.
- S_WAIT: decrement the counter. At 0, go to S_LATCH. item_data is sampled exactly RAM_LATENCY cycles after draw_index was updated.
- S_LATCH: register rx=item_data[27:19] (9 low bits), ry=item_data[14:7] (8 low bits), type, visible; clear dx/dy.
  - If visible==0: go to S_NEXT.
  - Otherwise: go to S_DRAW.
  - Items with moving==1 are drawn normally.
- S_DRAW: one pixel per cycle, row-major.
  - dx increments 0..SIZE-1; on wrap dy increments.
  - Outputs: x=rx+dx, y=ry+dy, colour from type.
  - plot=1 only if the 10-bit sums satisfy rx+dx<SCREEN_W and ry+dy<SCREEN_H. Clipped pixels consume their cycle with plot=0.
  - After dx=dy=SIZE-1, go to S_NEXT. Duration is exactly SIZE*SIZE cycles.
- S_NEXT:
  - If draw_index==quantity-1: go to S_DONE.
  - Otherwise: draw_index<=draw_index+1, go to S_REQ.
  - Index never wraps past 15; quantity=15 gives indices 0..14.
- S_DONE: done=1 for one cycle, draw_stone_flag<=0, busy<=0, go to S_IDLE.
- draw_stone_flag is high from S_REQ of index 0 through S_NEXT of the last index, and low in S_IDLE/S_DONE.
- draw_index holds its last value when idle.
- Outputs x/y/colour/plot are registered; plot is never high outside S_DRAW.
- Sweep length: for N items with V visible, 1 + N*(2+RAM_LATENCY) + V*SIZE*SIZE + 1 cycles from start to done (±1 for state boundaries; the bench checks done within that window).

Test Plan:
- quantity=0, start pulse -> done pulses exactly once within 2 cycles; no plot, draw_stone_flag never high.
- quantity=1, record X=100, Y=50, type=01, visible=1 -> exactly 256 plots, covering x 100..115 and y 50..65 once each, colour 9'b111110000. Row-major order: first (100,50), last (115,65). done follows.
- quantity=3, item1 visible=0, items 0 and 2 visible -> 512 plots total, none with item1's coordinates. draw_index sequence 0,1,2 each held ≥RAM_LATENCY cycles before sampling; flag high throughout.
- Record X=310, Y=230, type=10 -> plot count 10*10=100, no pixel with x≥320 or y≥240, colour 9'b000111111, sweep still takes 256 draw cycles.
- start asserted again mid-sweep -> ignored, single done. Then reset asserted at draw pixel 37 -> next cycle plot=0, busy=0, flag=0, done=0. A fresh start after reset performs a complete sweep.
- Model of 2-cycle RAM with records changed every cycle except at the sampled cycle -> rendered colour/position match only the record present RAM_LATENCY cycles after each draw_index change.
